// File: rtl/ir_nec_pkg.sv
// ---------------------------------------------------------------------------
// ir_nec_pkg
// Shared definitions for the NEC IR link (receiver and transmitter):
//   - NEC timing limits in 50 MHz clock cycles
//   - receiver state encoding (also exported on rx_status_o)
//   - 32-bit frame layout: {inv_cmd[31:24], cmd[23:16], addr[15:0]}
// No ports (package).
// ---------------------------------------------------------------------------
package ir_nec_pkg;

   // Duration counter width; 20 bits covers the longest legal interval (10 ms)
   localparam int NEC_CNT_W = 20;

   // Timing limits in clk cycles at 50 MHz
   localparam logic [NEC_CNT_W-1:0] NEC_LEAD_MARK_MIN  = 20'd400000;  // 8 ms
   localparam logic [NEC_CNT_W-1:0] NEC_LEAD_MARK_MAX  = 20'd500000;  // 10 ms
   localparam logic [NEC_CNT_W-1:0] NEC_LEAD_SPACE_MIN = 20'd200000;  // 4 ms
   localparam logic [NEC_CNT_W-1:0] NEC_LEAD_SPACE_MAX = 20'd250000;  // 5 ms
   localparam logic [NEC_CNT_W-1:0] NEC_RPT_SPACE_MIN  = 20'd100000;  // 2 ms
   localparam logic [NEC_CNT_W-1:0] NEC_RPT_SPACE_MAX  = 20'd125000;  // 2.5 ms
   localparam logic [NEC_CNT_W-1:0] NEC_BIT_MARK_MIN   = 20'd20000;   // 400 us
   localparam logic [NEC_CNT_W-1:0] NEC_BIT_MARK_MAX   = 20'd35000;   // 700 us
   localparam logic [NEC_CNT_W-1:0] NEC_ZERO_SPACE_MIN = 20'd20000;
   localparam logic [NEC_CNT_W-1:0] NEC_ZERO_SPACE_MAX = 20'd35000;
   localparam logic [NEC_CNT_W-1:0] NEC_ONE_SPACE_MIN  = 20'd75000;   // 1.5 ms
   localparam logic [NEC_CNT_W-1:0] NEC_ONE_SPACE_MAX  = 20'd95000;   // 1.9 ms

   // Receiver state encoding
   localparam logic [3:0] RX_IDLE       = 4'd0;
   localparam logic [3:0] RX_LEAD_MARK  = 4'd1;
   localparam logic [3:0] RX_LEAD_SPACE = 4'd2;
   localparam logic [3:0] RX_BIT_MARK   = 4'd3;
   localparam logic [3:0] RX_BIT_SPACE  = 4'd4;
   localparam logic [3:0] RX_STOP       = 4'd5;
   localparam logic [3:0] RX_RPT_STOP   = 4'd6;

   // Frame field positions (bits arrive LSB-first)
   localparam int FRAME_ADDR_LSB = 0;
   localparam int FRAME_ADDR_MSB = 15;
   localparam int FRAME_CMD_LSB  = 16;
   localparam int FRAME_CMD_MSB  = 23;
   localparam int FRAME_INV_LSB  = 24;
   localparam int FRAME_INV_MSB  = 31;

   // Inclusive range test on a measured duration
   function automatic logic in_range(input logic [NEC_CNT_W-1:0] cnt,
                                     input logic [NEC_CNT_W-1:0] lo,
                                     input logic [NEC_CNT_W-1:0] hi);
      return (cnt >= lo) && (cnt <= hi);
   endfunction

endpackage

// File: rtl/ir_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// ir_rx_sync_edge
// Two-flop synchronizer for the asynchronous IR input followed by a
// registered edge detector. Pulses appear 3 clk after the input transition.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   ir_i    in   asynchronous IR level (idle high)
//   fall_o  out  one-cycle pulse, high->low seen (mark start)
//   rise_o  out  one-cycle pulse, low->high seen (mark end)
// ---------------------------------------------------------------------------
module ir_rx_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic ir_i,
   output logic fall_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic fall_q;
   logic rise_q;

   // Flops reset to the idle-high level so reset release never fakes an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= ir_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         fall_q <= prev_q & ~sync_q;
         rise_q <= ~prev_q & sync_q;
      end
   end

   assign fall_o = fall_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/ir_receiver_nec.sv
// ---------------------------------------------------------------------------
// ir_receiver_nec
// NEC IR frame decoder. Measures mark/space durations of the demodulated,
// active-low IR signal, shifts in 32 bits LSB-first, checks the command byte
// against its inverted copy and presents address/command with a one-cycle
// valid strobe. Malformed or timed-out frames give a one-cycle error pulse.
//
// Build option: define IR_RX_REPEAT_EN to decode NEC repeat codes
// (leader mark + 2.25 ms space + stop mark). Without it, repeat_o is tied
// low and a repeat-length leader space is treated as an error.
//
// Ports:
//   clk           in   50 MHz system clock
//   rst_n         in   asynchronous active-low reset
//   ir_in_i       in   demodulated IR, asynchronous, idle high, mark low
//   addr_o        out  [15:0] address of last valid frame
//   cmd_o         out  [7:0]  command of last valid frame
//   data_valid_o  out  one-cycle pulse, new addr/cmd
//   repeat_o      out  one-cycle pulse, repeat code received
//   error_o       out  one-cycle pulse, frame aborted
//   busy_o        out  high whenever the receiver is not idle
//   rx_status_o   out  [3:0] current state encoding (debug)
// ---------------------------------------------------------------------------
module ir_receiver_nec
   import ir_nec_pkg::*;
#(
   parameter logic [NEC_CNT_W-1:0] LEAD_MARK_MIN  = NEC_LEAD_MARK_MIN,
   parameter logic [NEC_CNT_W-1:0] LEAD_MARK_MAX  = NEC_LEAD_MARK_MAX,
   parameter logic [NEC_CNT_W-1:0] LEAD_SPACE_MIN = NEC_LEAD_SPACE_MIN,
   parameter logic [NEC_CNT_W-1:0] LEAD_SPACE_MAX = NEC_LEAD_SPACE_MAX,
   parameter logic [NEC_CNT_W-1:0] RPT_SPACE_MIN  = NEC_RPT_SPACE_MIN,
   parameter logic [NEC_CNT_W-1:0] RPT_SPACE_MAX  = NEC_RPT_SPACE_MAX,
   parameter logic [NEC_CNT_W-1:0] BIT_MARK_MIN   = NEC_BIT_MARK_MIN,
   parameter logic [NEC_CNT_W-1:0] BIT_MARK_MAX   = NEC_BIT_MARK_MAX,
   parameter logic [NEC_CNT_W-1:0] ZERO_SPACE_MIN = NEC_ZERO_SPACE_MIN,
   parameter logic [NEC_CNT_W-1:0] ZERO_SPACE_MAX = NEC_ZERO_SPACE_MAX,
   parameter logic [NEC_CNT_W-1:0] ONE_SPACE_MIN  = NEC_ONE_SPACE_MIN,
   parameter logic [NEC_CNT_W-1:0] ONE_SPACE_MAX  = NEC_ONE_SPACE_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ir_in_i,
   output logic [15:0] addr_o,
   output logic [7:0]  cmd_o,
   output logic        data_valid_o,
   output logic        repeat_o,
   output logic        error_o,
   output logic        busy_o,
   output logic [3:0]  rx_status_o
);

`ifdef IR_RX_REPEAT_EN
   localparam logic REPEAT_EN = 1'b1;
`else
   localparam logic REPEAT_EN = 1'b0;
`endif

   // Timeout fires on the first cycle the count exceeds the state's maximum
   localparam logic [NEC_CNT_W-1:0] LEAD_MARK_TO  = LEAD_MARK_MAX  + NEC_CNT_W'(1);
   localparam logic [NEC_CNT_W-1:0] LEAD_SPACE_TO = LEAD_SPACE_MAX + NEC_CNT_W'(1);
   localparam logic [NEC_CNT_W-1:0] BIT_MARK_TO   = BIT_MARK_MAX   + NEC_CNT_W'(1);
   localparam logic [NEC_CNT_W-1:0] BIT_SPACE_TO  = ONE_SPACE_MAX  + NEC_CNT_W'(1);
   localparam logic [NEC_CNT_W-1:0] CNT_SAT       = '1;

   logic                 fall_w;
   logic                 rise_w;
   logic                 edge_w;
   logic                 abort_w;
   logic                 rpt_space_ok_w;
   logic                 inv_ok_w;

   logic [3:0]           state_q,      state_d;
   logic [NEC_CNT_W-1:0] count_q,      count_d;
   logic [31:0]          shift_q,      shift_d;
   logic [5:0]           bit_cnt_q,    bit_cnt_d;
   logic [15:0]          addr_q,       addr_d;
   logic [7:0]           cmd_q,        cmd_d;
   logic                 dv_q,         dv_d;
   logic                 rpt_q,        rpt_d;
   logic                 err_q,        err_d;
   logic                 have_frame_q, have_frame_d;

   ir_rx_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .ir_i   (ir_in_i),
      .fall_o (fall_w),
      .rise_o (rise_w)
   );

   assign edge_w         = fall_w | rise_w;
   // Constant-false when repeat decoding is not built in, so RX_RPT_STOP
   // becomes unreachable and is trimmed
   assign rpt_space_ok_w = REPEAT_EN & in_range(count_q, RPT_SPACE_MIN, RPT_SPACE_MAX);
   assign inv_ok_w       = (shift_q[FRAME_INV_MSB:FRAME_INV_LSB] ==
                            ~shift_q[FRAME_CMD_MSB:FRAME_CMD_LSB]);

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      addr_d       = addr_q;
      cmd_d        = cmd_q;
      have_frame_d = have_frame_q;
      dv_d         = 1'b0;
      rpt_d        = 1'b0;
      err_d        = 1'b0;
      abort_w      = 1'b0;

      // One counter times every interval: restart on each edge, saturate
      if (edge_w) begin
         count_d = '0;
      end else if (count_q == CNT_SAT) begin
         count_d = count_q;
      end else begin
         count_d = count_q + NEC_CNT_W'(1);
      end

      // In every active state the timeout check comes first, so an edge
      // landing on the timeout cycle is still an error.
      case (state_q)
         RX_IDLE: begin
            if (fall_w) state_d = RX_LEAD_MARK;
         end
         RX_LEAD_MARK: begin
            if (count_q == LEAD_MARK_TO) begin
               abort_w = 1'b1;
            end else if (rise_w && in_range(count_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
               state_d = RX_LEAD_SPACE;
            end else if (edge_w) begin
               abort_w = 1'b1;
            end
         end
         RX_LEAD_SPACE: begin
            if (count_q == LEAD_SPACE_TO) begin
               abort_w = 1'b1;
            end else if (fall_w && in_range(count_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
               bit_cnt_d = '0;
               state_d   = RX_BIT_MARK;
            end else if (fall_w && rpt_space_ok_w) begin
               state_d = RX_RPT_STOP;
            end else if (edge_w) begin
               abort_w = 1'b1;
            end
         end
         RX_BIT_MARK: begin
            if (count_q == BIT_MARK_TO) begin
               abort_w = 1'b1;
            end else if (rise_w && in_range(count_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
               state_d = RX_BIT_SPACE;
            end else if (edge_w) begin
               abort_w = 1'b1;
            end
         end
         RX_BIT_SPACE: begin
            if (count_q == BIT_SPACE_TO) begin
               abort_w = 1'b1;
            end else if (fall_w) begin
               // LSB-first: shifting right leaves the first bit at [0]
               if (in_range(count_q, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
                  shift_d = {1'b0, shift_q[31:1]};
               end else if (in_range(count_q, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                  shift_d = {1'b1, shift_q[31:1]};
               end else begin
                  abort_w = 1'b1;
               end
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == 6'd31) ? RX_STOP : RX_BIT_MARK;
            end else if (rise_w) begin
               abort_w = 1'b1;
            end
         end
         RX_STOP: begin
            if (count_q == BIT_MARK_TO) begin
               abort_w = 1'b1;
            end else if (rise_w && in_range(count_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
               if (inv_ok_w) begin
                  addr_d       = shift_q[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
                  cmd_d        = shift_q[FRAME_CMD_MSB:FRAME_CMD_LSB];
                  dv_d         = 1'b1;
                  have_frame_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = RX_IDLE;
            end else if (edge_w) begin
               abort_w = 1'b1;
            end
         end
         RX_RPT_STOP: begin
            if (count_q == BIT_MARK_TO) begin
               abort_w = 1'b1;
            end else if (rise_w && in_range(count_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
               // A repeat with no earlier frame has nothing to repeat: drop it
               rpt_d   = have_frame_q;
               state_d = RX_IDLE;
            end else if (edge_w) begin
               abort_w = 1'b1;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase

      if (abort_w) begin
         err_d   = 1'b1;
         state_d = RX_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RX_IDLE;
         count_q      <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         addr_q       <= '0;
         cmd_q        <= '0;
         dv_q         <= 1'b0;
         rpt_q        <= 1'b0;
         err_q        <= 1'b0;
         have_frame_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         addr_q       <= addr_d;
         cmd_q        <= cmd_d;
         dv_q         <= dv_d;
         rpt_q        <= rpt_d;
         err_q        <= err_d;
         have_frame_q <= have_frame_d;
      end
   end

   assign addr_o       = addr_q;
   assign cmd_o        = cmd_q;
   assign data_valid_o = dv_q;
   assign repeat_o     = REPEAT_EN & rpt_q;
   assign error_o      = err_q;
   assign busy_o       = (state_q != RX_IDLE);
   assign rx_status_o  = state_q;

endmodule

// File: tb/tb_ir_receiver_nec.sv
// ---------------------------------------------------------------------------
// tb_ir_receiver_nec
// Bench for ir_receiver_nec with NEC timing scaled down 1000x so complete
// frames fit in a short run. Stimulus pushes the expected event
// (valid / repeat / error with the addr/cmd that must be visible) into a
// queue; a monitor pops and compares on every output pulse.
// ---------------------------------------------------------------------------
module tb_ir_receiver_nec;

   // Scaled limits (cycles)
   localparam logic [19:0] LM_MIN = 20'd400, LM_MAX = 20'd500;
   localparam logic [19:0] LS_MIN = 20'd200, LS_MAX = 20'd250;
   localparam logic [19:0] RS_MIN = 20'd100, RS_MAX = 20'd125;
   localparam logic [19:0] BM_MIN = 20'd20,  BM_MAX = 20'd35;
   localparam logic [19:0] ZS_MIN = 20'd20,  ZS_MAX = 20'd35;
   localparam logic [19:0] OS_MIN = 20'd75,  OS_MAX = 20'd95;

   // Nominal durations (9 ms, 4.5 ms, 2.25 ms, 560 us, 560 us, 1.69 ms)
   localparam int NOM_LM = 450, NOM_LS = 225, NOM_RS = 112;
   localparam int NOM_BM = 28,  NOM_ZS = 28,  NOM_OS = 84;
   localparam int GAP    = 60;

   localparam logic [2:0] EV_VALID = 3'b100;
   localparam logic [2:0] EV_RPT   = 3'b010;
   localparam logic [2:0] EV_ERR   = 3'b001;

`ifdef IR_RX_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] addr;
      logic [7:0]  cmd;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_in = 1'b1;
   logic [15:0] addr_o;
   logic [7:0]  cmd_o;
   logic        data_valid_o, repeat_o, error_o, busy_o;
   logic [3:0]  rx_status_o;

   ev_t         exp_q[$];
   ev_t         mon_ev;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          err_cyc = -1;

   // Reference model state
   logic [15:0] m_addr = '0;
   logic [7:0]  m_cmd = '0;
   bit          m_have = 1'b0;
   int          pct_fix = 0;
   bit          jit_rnd = 1'b0;

   ir_receiver_nec #(
      .LEAD_MARK_MIN(LM_MIN),  .LEAD_MARK_MAX(LM_MAX),
      .LEAD_SPACE_MIN(LS_MIN), .LEAD_SPACE_MAX(LS_MAX),
      .RPT_SPACE_MIN(RS_MIN),  .RPT_SPACE_MAX(RS_MAX),
      .BIT_MARK_MIN(BM_MIN),   .BIT_MARK_MAX(BM_MAX),
      .ZERO_SPACE_MIN(ZS_MIN), .ZERO_SPACE_MAX(ZS_MAX),
      .ONE_SPACE_MIN(OS_MIN),  .ONE_SPACE_MAX(OS_MAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ir_in_i      (ir_in),
      .addr_o       (addr_o),
      .cmd_o        (cmd_o),
      .data_valid_o (data_valid_o),
      .repeat_o     (repeat_o),
      .error_o      (error_o),
      .busy_o       (busy_o),
      .rx_status_o  (rx_status_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every output pulse must match the next expected event
   always @(negedge clk) begin
      if (rst_n && (data_valid_o || repeat_o || error_o)) begin
         if (error_o) err_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got dv/rpt/err=%b, expected none (cycle %0d)",
                     {data_valid_o, repeat_o, error_o}, cyc);
         end else begin
            mon_ev = exp_q.pop_front();
            check("event_kind", {29'd0, data_valid_o, repeat_o, error_o}, {29'd0, mon_ev.kind});
            check("event_addr", {16'd0, addr_o}, {16'd0, mon_ev.addr});
            check("event_cmd",  {24'd0, cmd_o},  {24'd0, mon_ev.cmd});
         end
      end
   end

   // Global time bound
   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got no completion, expected finish before 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   function automatic int dur(input int nom);
      int p;
      p = jit_rnd ? (int'($urandom_range(16, 0)) - 8) : pct_fix;
      return nom * (100 + p) / 100;
   endfunction

   task automatic drive(input logic lvl, input int n);
      ir_in = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},   {16'd0, addr_o}, 32'd0);
      check({tag, "_cmd"},    {24'd0, cmd_o}, 32'd0);
      check({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
      check({tag, "_status"}, {28'd0, rx_status_o}, 32'd0);
      check({tag, "_pulses"}, {29'd0, data_valid_o, repeat_o, error_o}, 32'd0);
   endtask

   // Sends one frame; abort_bit >= 0 asserts reset during that bit's mark
   task automatic send_frame(input logic [15:0] a, input logic [7:0] c,
                             input logic [7:0] inv, input int abort_bit);
      logic [31:0] f;
      f = {inv, c, a};
      drive(1'b0, dur(NOM_LM));
      drive(1'b1, dur(NOM_LS));
      for (int i = 0; i < 32; i++) begin
         if (i == abort_bit) begin
            drive(1'b0, 10);
            rst_n  = 1'b0;
            ir_in  = 1'b1;
            m_addr = '0;
            m_cmd  = '0;
            m_have = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check_reset_outputs("midframe_reset");
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            drive(1'b1, GAP);
            return;
         end
         drive(1'b0, dur(NOM_BM));
         drive(1'b1, f[i] ? dur(NOM_OS) : dur(NOM_ZS));
      end
      drive(1'b0, dur(NOM_BM));
      drive(1'b1, GAP);
   endtask

   // Model: a frame is accepted exactly when the last byte inverts the command
   task automatic do_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] inv);
      if (inv == ~c) begin
         exp_q.push_back('{EV_VALID, a, c});
         m_addr = a;
         m_cmd  = c;
         m_have = 1'b1;
      end else begin
         exp_q.push_back('{EV_ERR, m_addr, m_cmd});
      end
      $display("frame addr=%h cmd=%h inv=%h expect=%s", a, c, inv,
               (inv == ~c) ? "valid" : "error");
      send_frame(a, c, inv, -1);
   endtask

   task automatic do_repeat();
      if (!RPT_EN) exp_q.push_back('{EV_ERR, m_addr, m_cmd});
      else if (m_have) exp_q.push_back('{EV_RPT, m_addr, m_cmd});
      $display("repeat code have_frame=%0d repeat_en=%0d", m_have, RPT_EN);
      drive(1'b0, dur(NOM_LM));
      drive(1'b1, dur(NOM_RS));
      drive(1'b0, dur(NOM_BM));
      drive(1'b1, GAP);
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check(name, exp_q.size(), 32'd0);
   endtask

   initial begin
      int c0;
      logic [15:0] ra;
      logic [7:0]  rc, ri;

      // Reset and 1 ms of idle line
      repeat (4) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      drive(1'b1, 50);
      check_reset_outputs("idle");

      // Repeat before any frame: silent when enabled, error otherwise
      do_repeat();
      wait_drain("drain_repeat_noframe");

      // Nominal frame, then +8% and -8% timing
      pct_fix = 0;
      do_frame(16'h00FF, 8'h12, 8'hED);
      wait_drain("drain_nominal");
      pct_fix = 8;
      do_frame(16'h00FF, 8'h12, 8'hED);
      wait_drain("drain_plus8");
      pct_fix = -8;
      do_frame(16'h00FF, 8'h12, 8'hED);
      wait_drain("drain_minus8");
      pct_fix = 0;

      // Wrong inverted byte
      do_frame(16'h00FF, 8'h12, 8'hEC);
      wait_drain("drain_bad_inv");

      // Repeat after a valid frame
      do_repeat();
      wait_drain("drain_repeat");

      // 12 ms leader: timeout on the cycle the count reaches MAX+1.
      // Fall -> 3 clk sync/edge -> 1 clk counter clear -> MAX+1 counts -> 1 clk register
      $display("long leader mark 600 cycles expect error");
      exp_q.push_back('{EV_ERR, m_addr, m_cmd});
      err_cyc = -1;
      c0 = cyc;
      drive(1'b0, 600);
      check("timeout_cycle", err_cyc - c0, LM_MAX + 6);
      check("timeout_busy", {31'd0, busy_o}, 32'd0);
      drive(1'b1, GAP);
      wait_drain("drain_timeout");
      do_frame(16'h00FF, 8'h34, 8'hCB);
      wait_drain("drain_after_timeout");

      // Reset during bit 10, then a full frame
      $display("frame addr=a55a cmd=01 reset during bit 10");
      send_frame(16'hA55A, 8'h01, 8'hFE, 10);
      check_reset_outputs("after_reset");
      do_frame(16'hA55A, 8'h01, 8'hFE);
      wait_drain("drain_a55a");

      // Randomized frames with per-segment jitter within +/-8%
      jit_rnd = 1'b1;
      for (int r = 0; r < 6; r++) begin
         ra = 16'($urandom);
         rc = 8'($urandom);
         ri = ~rc;
         if ($urandom_range(3, 0) == 0) ri = ri ^ (8'd1 << $urandom_range(7, 0));
         do_frame(ra, rc, ri);
         wait_drain("drain_random");
         if ($urandom_range(1, 0) == 1) begin
            do_repeat();
            wait_drain("drain_random_repeat");
         end
      end

      drive(1'b1, 20);
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
